// File: rtl/async_fifo_pkg.sv
// Shared constants, pointer type and occupancy helper for the single-clock byte FIFO.
package async_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF:0] ptr_t;

    // Pointer difference modulo 2^ptr_w; pointers are zero-extended to 32 bits so any depth works.
    function automatic logic [31:0] occupancy(input logic [31:0] wr, input logic [31:0] rd,
                                              input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port register array: synchronous write, synchronous registered read.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage is intentionally not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/async_fifo.sv
// Single-clock byte FIFO with level flags and overflow/underflow reporting.
// Define ASYNCFIFO_STICKY_ERR_EN for sticky error flags cleared by clr_err.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
`ifdef ASYNCFIFO_STICKY_ERR_EN
    input  logic              clr_err,
`endif
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] occ_c;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic            wr_acc_c;
    logic            rd_acc_c;

    // Level flags straight from the registered pointers.
    always_comb begin
        occ_c        = PTR_W'(occupancy(32'(wr_ptr_q), 32'(rd_ptr_q), PTR_W));
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        almost_full  = (occ_c >= PTR_W'(AF_LEVEL));
        almost_empty = (occ_c <= PTR_W'(AE_LEVEL));
    end

    always_comb begin
        wr_acc_c = wr_en && !full;
        rd_acc_c = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

`ifdef ASYNCFIFO_STICKY_ERR_EN
    // A new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        ovf_d = (wr_en && full)  || (ovf_q && !clr_err);
        udf_d = (rd_en && empty) || (udf_q && !clr_err);
    end
`else
    always_comb begin
        ovf_d = wr_en && full;
        udf_d = rd_en && empty;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;

    async_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_c),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (din),
        .re    (rd_acc_c),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Scenario bench for async_fifo with a queue-based reference model and random traffic.
module tb_async_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef ASYNCFIFO_STICKY_ERR_EN
    logic       clr_err = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_dout = 8'h00;
    logic       exp_ovf  = 1'b0;
    logic       exp_udf  = 1'b0;

    always #5 clk = ~clk;

    async_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
`ifdef ASYNCFIFO_STICKY_ERR_EN
        .clr_err      (clr_err),
`endif
        .din          (din),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // One clock of stimulus; the model advances from its own state at the same edge.
    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        bit was_full, was_empty;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
`ifdef ASYNCFIFO_STICKY_ERR_EN
        exp_ovf = exp_ovf || (w && was_full);
        exp_udf = exp_udf || (r && was_empty);
`else
        exp_ovf = w && was_full;
        exp_udf = r && was_empty;
`endif
        if (r && !was_empty) exp_dout = mq.pop_front();
        if (w && !was_full) mq.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_dout = 8'h00;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        model_reset();
        #20;
        rst = 1'b0;
        #1;
        total++; if (empty !== 1'b1)        begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b want=1", almost_empty); end
        total++; if (full !== 1'b0)         begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (almost_full !== 1'b0)  begin bad++; $display("FAIL reset_afull got=%b want=0", almost_full); end
        total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        total++; if (underflow !== 1'b0)    begin bad++; $display("FAIL reset_udf got=%b want=0", underflow); end
        total++; if (dout !== 8'h00)        begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
    endtask

    task automatic test_burst();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            drive(1'b0, 1'b0, 8'h00);
        end
        drive(1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            total++; if (dout !== 8'(i)) begin bad++; $display("FAIL burst_dout[%0d] got=%h want=%h", i, dout, 8'(i)); end
            total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
                bad++; $display("FAIL burst_err[%0d] got=%b%b want=00", i, overflow, underflow);
            end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL burst_empty got=%b want=1", empty); end
    endtask

    task automatic test_fill();
        logic [7:0] data [16];
        for (int i = 0; i < 16; i++) begin
            data[i] = 8'($urandom);
            if (data[i] == 8'hAA) data[i] = 8'hAB;
            drive(1'b1, 1'b0, data[i]);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
        drive(1'b1, 1'b0, 8'hAA);
        total++; if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
            bad++; $display("FAIL fill_ovf_pulse got=%b want=1", overflow);
        end
        drive(1'b0, 1'b0, 8'h00);
        total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL fill_ovf_after got=%b want=%b", overflow, exp_ovf); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            total++; if (dout !== data[i]) begin bad++; $display("FAIL fill_dout[%0d] got=%h want=%h", i, dout, data[i]); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drained got=%b want=1", empty); end
    endtask

    task automatic test_underflow();
        logic [7:0] held;
        held = dout;
        drive(1'b0, 1'b1, 8'h00);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%b want=1", underflow); end
        total++; if (dout !== held)      begin bad++; $display("FAIL udf_dout got=%h want=%h", dout, held); end
        drive(1'b0, 1'b0, 8'h00);
        total++; if (underflow !== exp_udf) begin bad++; $display("FAIL udf_after got=%b want=%b", underflow, exp_udf); end
        drive(1'b1, 1'b0, 8'h5C);
        drive(1'b0, 1'b1, 8'h00);
        total++; if (dout !== 8'h5C) begin bad++; $display("FAIL udf_rdptr got=%h want=5c", dout); end
    endtask

    task automatic test_thresholds();
        for (int n = 1; n <= 16; n++) begin
            drive(1'b1, 1'b0, 8'(n + 32));
            total++; if (almost_empty !== (n <= 2)) begin bad++; $display("FAIL thr_ae[%0d] got=%b want=%b", n, almost_empty, n <= 2); end
            total++; if (almost_full !== (n >= 14)) begin bad++; $display("FAIL thr_af[%0d] got=%b want=%b", n, almost_full, n >= 14); end
            total++; if (full !== (n == 16))        begin bad++; $display("FAIL thr_full[%0d] got=%b want=%b", n, full, n == 16); end
            total++; if (empty !== 1'b0)            begin bad++; $display("FAIL thr_empty[%0d] got=%b want=0", n, empty); end
        end
        for (int n = 15; n >= 0; n--) begin
            drive(1'b0, 1'b1, 8'h00);
            total++; if (dout !== 8'(48 - n)) begin bad++; $display("FAIL thr_dout[%0d] got=%h want=%h", n, dout, 8'(48 - n)); end
            total++; if (almost_empty !== (n <= 2) || almost_full !== (n >= 14)) begin
                bad++; $display("FAIL thr_drain[%0d] got=%b%b want=%b%b", n, almost_empty, almost_full, n <= 2, n >= 14);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 8'(i + 5));
            total++; if (dout !== 8'(i)) begin bad++; $display("FAIL wrap_dout[%0d] got=%h want=%h", i, dout, 8'(i)); end
            total++; if (mq.size() != 5 || empty !== 1'b0 || almost_empty !== 1'b0 || almost_full !== 1'b0 || full !== 1'b0) begin
                bad++; $display("FAIL wrap_flags[%0d] got=e%b ae%b af%b f%b want=e0 ae0 af0 f0", i, empty, almost_empty, almost_full, full);
            end
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_rst_empty got=%b want=1", empty); end
        total++; if (dout !== 8'h00 || full !== 1'b0) begin bad++; $display("FAIL wrap_rst_state got=%h/%b want=00/0", dout, full); end
        wr_en = 1'b0; rd_en = 1'b0;
        #10;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int pw, pr;
        for (int i = 0; i < 600; i++) begin
            pw = (i % 200 < 100) ? 75 : 30;
            pr = (i % 200 < 100) ? 30 : 75;
            drive(1'($urandom_range(99) < pw), 1'($urandom_range(99) < pr), 8'($urandom));
            total++;
            if (dout !== exp_dout || overflow !== exp_ovf || underflow !== exp_udf ||
                empty !== (mq.size() == 0) || full !== (mq.size() == 16) ||
                almost_empty !== (mq.size() <= 2) || almost_full !== (mq.size() >= 14)) begin
                bad++;
                $display("FAIL rand[%0d] got=d%h o%b u%b e%b f%b ae%b af%b want=d%h o%b u%b occ=%0d",
                         i, dout, overflow, underflow, empty, full, almost_empty, almost_full,
                         exp_dout, exp_ovf, exp_udf, mq.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_fill();
        test_underflow();
        test_thresholds();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
